// File: rtl/fma_lza_normalizer.sv
// FMA post-adder normalizer: leading-zero anticipation on the adder operands,
// left normalization of the positive sum with one-bit LZA correction, and
// exponent adjustment. Two-stage valid/ready pipeline towards the rounder.
module fma_lza_normalizer #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  input  logic                   In_valid_i,
  output logic                   In_ready_o,
  input  logic [3*PARM_MANT+4:0] PosSum_i,
  input  logic [3*PARM_MANT+4:0] A_LZA_i,
  input  logic [3*PARM_MANT+4:0] B_LZA_i,
  input  logic                   Sign_i,
  input  logic                   Minus_sticky_bit_i,
  input  logic [PARM_EXP+1:0]    Exp_i,
  input  logic [2:0]             Special_i,
  output logic                   Out_valid_o,
  input  logic                   Out_ready_i,
  output logic [PARM_MANT+2:0]   Mant_o,
  output logic                   Sticky_o,
  output logic [PARM_EXP+1:0]    Exp_o,
  output logic                   Sign_o,
  output logic                   Zero_o,
  output logic [2:0]             Special_o
);

  localparam int W  = 3*PARM_MANT+5;
  localparam int LW = $clog2(W);
  localparam int EW = PARM_EXP+2;
  localparam int MW = PARM_MANT+3;

  // Handshake
  logic v1, v2;
  logic r1, r2;
  logic load1, load2;

  assign r2          = ~v2 | Out_ready_i;
  assign r1          = ~v1 | r2;
  assign In_ready_o  = r1;
  assign load1       = In_valid_i & r1;
  assign load2       = v1 & r2;
  assign Out_valid_o = v2;

  // Stage 1 combinational: indicator string and its leading-zero count
  logic [W-1:0]  lza_f;
  logic [LW-1:0] lz_pred;

  // Indicator f[i] = (A^B)[i] ^ (A|B)[i-1]; f[0] forced high so the count never exceeds W-1
  always_comb begin
    lza_f = {(A_LZA_i[W-1:1] ^ B_LZA_i[W-1:1]) ^ (A_LZA_i[W-2:0] | B_LZA_i[W-2:0]), 1'b1};
  end

  // Priority encoder from the MSB: first set indicator bit gives the predicted shift
  always_comb begin : lzc
    logic found;
    lz_pred = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && lza_f[W-1-i]) begin
        lz_pred = LW'(i);
        found   = 1'b1;
      end
    end
  end

  // Stage 1 registers
  logic [W-1:0]  sum1;
  logic [LW-1:0] lz1;
  logic [EW-1:0] exp1;
  logic          sign1;
  logic          msb1;
  logic [2:0]    spec1;
  logic          zero1;

  // Stage 1 capture; holds while stalled, refills on pass-through
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      v1    <= 1'b0;
      sum1  <= '0;
      lz1   <= '0;
      exp1  <= '0;
      sign1 <= 1'b0;
      msb1  <= 1'b0;
      spec1 <= '0;
      zero1 <= 1'b0;
    end else begin
      if (r1) v1 <= In_valid_i;
      if (load1) begin
        sum1  <= PosSum_i;
        lz1   <= lz_pred;
        exp1  <= Exp_i;
        sign1 <= Sign_i;
        msb1  <= Minus_sticky_bit_i;
        spec1 <= Special_i;
        zero1 <= (PosSum_i == '0);
      end
    end
  end

  // Stage 2 combinational: normalize, correct, adjust exponent
  logic [W-1:0]  shifted;
  logic [W-1:0]  norm;
  logic          corr;
  logic [MW-1:0] mant_n;
  logic          sticky_n;
  logic [EW-1:0] exp_n;

  // The prediction is the true count or one short, so at most one extra shift is needed
  always_comb begin
    shifted = sum1 << lz1;
    corr    = ~shifted[W-1];
    norm    = corr ? (shifted << 1) : shifted;
    if (zero1) begin
      mant_n   = '0;
      sticky_n = msb1;
      exp_n    = '0;
    end else begin
      mant_n   = norm[W-1 -: MW];
      sticky_n = (|norm[W-MW-1:0]) | msb1;
      exp_n    = exp1 - EW'(lz1) - EW'(corr);
    end
  end

  // Stage 2 / output registers; update only on a stage-2 load
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      v2        <= 1'b0;
      Mant_o    <= '0;
      Sticky_o  <= 1'b0;
      Exp_o     <= '0;
      Sign_o    <= 1'b0;
      Zero_o    <= 1'b0;
      Special_o <= '0;
    end else begin
      if (r2) v2 <= v1;
      if (load2) begin
        Mant_o    <= mant_n;
        Sticky_o  <= sticky_n;
        Exp_o     <= exp_n;
        Sign_o    <= sign1;
        Zero_o    <= zero1;
        Special_o <= spec1;
      end
    end
  end

endmodule

// File: tb/tb_fma_lza_normalizer.sv
// Self-checking bench for fma_lza_normalizer with a behavioural model that
// normalizes from the position of the sum's most significant set bit.
module tb_fma_lza_normalizer;

  localparam int W = 74;

  logic          Clk_CI;
  logic          Rst_RBI;
  logic          In_valid_i;
  logic          In_ready_o;
  logic [W-1:0]  PosSum_i;
  logic [W-1:0]  A_LZA_i;
  logic [W-1:0]  B_LZA_i;
  logic          Sign_i;
  logic          Minus_sticky_bit_i;
  logic [9:0]    Exp_i;
  logic [2:0]    Special_i;
  logic          Out_valid_o;
  logic          Out_ready_i;
  logic [25:0]   Mant_o;
  logic          Sticky_o;
  logic [9:0]    Exp_o;
  logic          Sign_o;
  logic          Zero_o;
  logic [2:0]    Special_o;

  fma_lza_normalizer #(.PARM_EXP(8), .PARM_MANT(23)) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
    .In_valid_i(In_valid_i), .In_ready_o(In_ready_o),
    .PosSum_i(PosSum_i), .A_LZA_i(A_LZA_i), .B_LZA_i(B_LZA_i),
    .Sign_i(Sign_i), .Minus_sticky_bit_i(Minus_sticky_bit_i),
    .Exp_i(Exp_i), .Special_i(Special_i),
    .Out_valid_o(Out_valid_o), .Out_ready_i(Out_ready_i),
    .Mant_o(Mant_o), .Sticky_o(Sticky_o), .Exp_o(Exp_o),
    .Sign_o(Sign_o), .Zero_o(Zero_o), .Special_o(Special_o)
  );

  typedef struct packed {
    logic [25:0] mant;
    logic        sticky;
    logic [9:0]  ex;
    logic        sign;
    logic        zero;
    logic [2:0]  spec;
  } res_t;

  int checks = 0;
  int errors = 0;

  initial Clk_CI = 1'b0;
  always #5 Clk_CI = ~Clk_CI;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic res_t observed();
    res_t r;
    r = {Mant_o, Sticky_o, Exp_o, Sign_o, Zero_o, Special_o};
    return r;
  endfunction

  // Position of the most significant set bit of the sum, -1 for zero
  function automatic int msb_pos(input logic [W-1:0] s);
    int p;
    p = -1;
    for (int i = 0; i < W; i++) if (s[i]) p = i;
    return p;
  endfunction

  // Reference: place the MSB of the sum at the hidden bit, 25 bits below it form
  // the fraction/guard/round field, anything further down is sticky.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [9:0] e, input logic sg, input logic ms,
                                 input logic [2:0] sp);
    res_t r;
    logic [W-1:0] s;
    int p;
    s = a + b;
    p = msb_pos(s);
    r.sign = sg;
    r.spec = sp;
    r.zero = 1'b0;
    if (p < 0) begin
      r.mant = '0;
      r.sticky = ms;
      r.ex = '0;
      r.zero = 1'b1;
    end else begin
      if (p >= 25) begin
        r.mant   = 26'(s >> (p - 25));
        r.sticky = ((s & ((W'(1) << (p - 25)) - W'(1))) != '0) | ms;
      end else begin
        r.mant   = 26'(s << (25 - p));
        r.sticky = ms;
      end
      r.ex = e + 10'(p) - 10'd73;
    end
    return r;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [9:0] e,
                      input logic sg, input logic ms, input logic [2:0] sp, output bit ok);
    A_LZA_i = a; B_LZA_i = b; PosSum_i = a + b;
    Exp_i = e; Sign_i = sg; Minus_sticky_bit_i = ms; Special_i = sp;
    In_valid_i = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge Clk_CI);
      if (In_ready_o) ok = 1'b1;
      @(posedge Clk_CI); #1;
    end
    In_valid_i = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk_CI);
      if (Out_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    res_t zero_r;
    zero_r = '0;
    Rst_RBI = 1'b0;
    #12;
    checks++;
    if (observed() !== zero_r) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", observed(), zero_r);
    end
    checks++;
    if (Out_valid_o !== 1'b0 || In_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_handshake: got valid=%b ready=%b expected valid=0 ready=1",
                         Out_valid_o, In_ready_o);
    end
    @(negedge Clk_CI); Rst_RBI = 1'b1;
    @(posedge Clk_CI); #1;
  endtask

  task automatic test_basic();
    res_t exp_r;
    bit ok;
    exp_r = '{mant: 26'h2000000, sticky: 1'b0, ex: 10'd127, sign: 1'b0, zero: 1'b0, spec: 3'b010};
    A_LZA_i = 74'd1 << 73; B_LZA_i = '0; #1;
    checks++;
    if (dut.lz_pred !== 7'd0) begin
      errors++; $display("FAIL basic_lz: got %0d expected 0", dut.lz_pred);
    end
    send(74'd1 << 73, '0, 10'd127, 1'b0, 1'b0, 3'b010, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_accept: got timeout expected accept"); end
    @(negedge Clk_CI);
    checks++;
    if (Out_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_latency_early: got valid=%b expected 0", Out_valid_o);
    end
    @(negedge Clk_CI);
    checks++;
    if (Out_valid_o !== 1'b1) begin
      errors++; $display("FAIL basic_latency: got valid=%b expected 1", Out_valid_o);
    end
    checks++;
    if (observed() !== exp_r) begin
      errors++; $display("FAIL basic_result: got %h expected %h", observed(), exp_r);
    end
    @(posedge Clk_CI); #1;
  endtask

  task automatic test_shift();
    res_t exp_r;
    bit ok;
    A_LZA_i = 74'd1 << 49; B_LZA_i = 74'd1 << 49; #1;
    checks++;
    if (dut.lz_pred !== 7'd23) begin
      errors++; $display("FAIL shift_lz: got %0d expected 23", dut.lz_pred);
    end
    send(74'd1 << 49, 74'd1 << 49, 10'd127, 1'b0, 1'b0, 3'b000, ok);
    wait_out(ok);
    exp_r = '{mant: 26'h2000000, sticky: 1'b0, ex: 10'd104, sign: 1'b0, zero: 1'b0, spec: 3'b000};
    checks++;
    if (!ok || observed() !== exp_r) begin
      errors++; $display("FAIL shift_result: got %h (valid=%b) expected %h", observed(), ok, exp_r);
    end
    @(posedge Clk_CI); #1;
    send((74'd1 << 73) | 74'd1, '0, 10'd127, 1'b0, 1'b0, 3'b000, ok);
    wait_out(ok);
    exp_r = '{mant: 26'h2000000, sticky: 1'b1, ex: 10'd127, sign: 1'b0, zero: 1'b0, spec: 3'b000};
    checks++;
    if (!ok || observed() !== exp_r) begin
      errors++; $display("FAIL sticky_result: got %h (valid=%b) expected %h", observed(), ok, exp_r);
    end
    @(posedge Clk_CI); #1;
  endtask

  task automatic test_lza_corr();
    res_t exp_r;
    bit ok;
    A_LZA_i = 74'd1; B_LZA_i = '0; #1;
    checks++;
    if (dut.lz_pred !== 7'd72) begin
      errors++; $display("FAIL corr_lz: got %0d expected 72", dut.lz_pred);
    end
    send(74'd1, '0, 10'd127, 1'b0, 1'b0, 3'b000, ok);
    wait_out(ok);
    exp_r = '{mant: 26'h2000000, sticky: 1'b0, ex: 10'd54, sign: 1'b0, zero: 1'b0, spec: 3'b000};
    checks++;
    if (!ok || observed() !== exp_r) begin
      errors++; $display("FAIL corr_result: got %h (valid=%b) expected %h", observed(), ok, exp_r);
    end
    @(posedge Clk_CI); #1;
  endtask

  task automatic test_zero();
    res_t exp_r;
    bit ok;
    send('0, '0, 10'd127, 1'b1, 1'b1, 3'b101, ok);
    wait_out(ok);
    exp_r = '{mant: 26'h0, sticky: 1'b1, ex: 10'd0, sign: 1'b1, zero: 1'b1, spec: 3'b101};
    checks++;
    if (!ok || observed() !== exp_r) begin
      errors++; $display("FAIL zero_result: got %h (valid=%b) expected %h", observed(), ok, exp_r);
    end
    @(posedge Clk_CI); #1;
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t prev, want;
    int sent = 0, got = 0;
    bit stalled_prev = 1'b0, saw_full = 1'b0;
    for (int k = 0; k < 30 && got < 3; k++) begin
      Out_ready_i = !(k >= 2 && k <= 5);
      if (sent < 3) begin
        A_LZA_i = (74'd1 << (60 - 17*sent)) | 74'(sent + 5);
        B_LZA_i = 74'h3 << (30 - 10*sent);
        PosSum_i = A_LZA_i + B_LZA_i;
        Exp_i = 10'(100 + sent); Sign_i = sent[0]; Minus_sticky_bit_i = 1'b0;
        Special_i = 3'(sent + 1);
        In_valid_i = 1'b1;
      end else begin
        In_valid_i = 1'b0;
      end
      @(negedge Clk_CI);
      if (stalled_prev) begin
        checks++;
        if (Out_valid_o !== 1'b1 || observed() !== prev) begin
          errors++; $display("FAIL b2b_stall_hold: got valid=%b %h expected valid=1 %h",
                             Out_valid_o, observed(), prev);
        end
      end
      if (!In_ready_o) saw_full = 1'b1;
      if (In_valid_i && In_ready_o) begin
        q.push_back(model(A_LZA_i, B_LZA_i, Exp_i, Sign_i, Minus_sticky_bit_i, Special_i));
        sent++;
      end
      if (Out_valid_o && Out_ready_i) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious: got %h expected no output", observed());
        end else begin
          want = q.pop_front();
          if (observed() !== want) begin
            errors++; $display("FAIL b2b_order: got %h expected %h", observed(), want);
          end
        end
        got++;
      end
      stalled_prev = Out_valid_o && !Out_ready_i;
      prev = observed();
      @(posedge Clk_CI); #1;
    end
    In_valid_i = 1'b0;
    Out_ready_i = 1'b1;
    checks++;
    if (sent != 3 || got != 3) begin
      errors++; $display("FAIL b2b_count: got sent=%0d out=%0d expected 3/3", sent, got);
    end
    checks++;
    if (!saw_full) begin
      errors++; $display("FAIL b2b_ready_drop: got In_ready always 1 expected a 0");
    end
  endtask

  task automatic test_reset_mid();
    res_t zero_r, want;
    bit ok;
    zero_r = '0;
    Out_ready_i = 1'b0;
    send(74'd1 << 40, 74'd7, 10'd200, 1'b1, 1'b1, 3'b111, ok);
    send(74'd1 << 20, 74'd1, 10'd300, 1'b1, 1'b0, 3'b110, ok);
    checks++;
    if (Out_valid_o !== 1'b1 || dut.v1 !== 1'b1) begin
      errors++; $display("FAIL midrst_fill: got valid=%b v1=%b expected 1/1", Out_valid_o, dut.v1);
    end
    #3 Rst_RBI = 1'b0;
    #1;
    checks++;
    if (Out_valid_o !== 1'b0 || observed() !== zero_r) begin
      errors++; $display("FAIL midrst_clear: got valid=%b %h expected valid=0 %h",
                         Out_valid_o, observed(), zero_r);
    end
    checks++;
    if (In_ready_o !== 1'b1) begin
      errors++; $display("FAIL midrst_ready: got %b expected 1", In_ready_o);
    end
    #2 Rst_RBI = 1'b1;
    @(posedge Clk_CI); #1;
    Out_ready_i = 1'b1;
    send(74'd9 << 30, 74'd5, 10'd50, 1'b0, 1'b0, 3'b001, ok);
    wait_out(ok);
    want = model(74'd9 << 30, 74'd5, 10'd50, 1'b0, 1'b0, 3'b001);
    checks++;
    if (!ok || observed() !== want) begin
      errors++; $display("FAIL midrst_after: got %h (valid=%b) expected %h", observed(), ok, want);
    end
    @(posedge Clk_CI); #1;
  endtask

  task automatic test_random(input int n);
    res_t q[$];
    res_t want;
    logic [W-1:0] a, b;
    int sent = 0, got = 0, p, tlz, nb;
    bit pending = 1'b0;
    for (int cyc = 0; cyc < n*20 && got < n; cyc++) begin
      if (!pending && sent < n) begin
        nb = $urandom_range(0, W-1);
        a = W'({$urandom, $urandom, $urandom}) & ((W'(1) << nb) - W'(1));
        b = W'({$urandom, $urandom, $urandom}) & ((W'(1) << $urandom_range(0, nb)) - W'(1));
        if ($urandom_range(0, 15) == 0) begin a = '0; b = '0; end
        A_LZA_i = a; B_LZA_i = b; PosSum_i = a + b;
        Exp_i = 10'($urandom); Sign_i = 1'($urandom); Minus_sticky_bit_i = 1'($urandom);
        Special_i = 3'($urandom);
        pending = 1'b1;
      end
      if (pending && !In_valid_i) In_valid_i = ($urandom_range(0, 3) != 0);
      Out_ready_i = ($urandom_range(0, 2) != 0);
      @(negedge Clk_CI);
      if (In_valid_i && In_ready_o) begin
        p = msb_pos(PosSum_i);
        if (p >= 0) begin
          tlz = 73 - p;
          checks++;
          if (!(int'(dut.lz_pred) == tlz || int'(dut.lz_pred) + 1 == tlz)) begin
            errors++; $display("FAIL rand_lz: got %0d expected %0d or %0d", dut.lz_pred, tlz - 1, tlz);
          end
        end
        q.push_back(model(A_LZA_i, B_LZA_i, Exp_i, Sign_i, Minus_sticky_bit_i, Special_i));
        sent++;
        pending = 1'b0;
      end
      if (Out_valid_o && Out_ready_i) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious: got %h expected no output", observed());
        end else begin
          want = q.pop_front();
          if (observed() !== want) begin
            errors++; $display("FAIL rand_result: got %h expected %h", observed(), want);
          end
        end
        got++;
      end
      @(posedge Clk_CI); #1;
      if (!pending) In_valid_i = 1'b0;
    end
    In_valid_i = 1'b0;
    Out_ready_i = 1'b1;
    checks++;
    if (got != n) begin
      errors++; $display("FAIL rand_count: got %0d results expected %0d", got, n);
    end
  endtask

  initial begin
    In_valid_i = 1'b0; Out_ready_i = 1'b1;
    A_LZA_i = '0; B_LZA_i = '0; PosSum_i = '0;
    Exp_i = '0; Sign_i = 1'b0; Minus_sticky_bit_i = 1'b0; Special_i = '0;
    test_reset();
    test_basic();
    test_shift();
    test_lza_corr();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_random(300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
